// File: rtl/dice_roller.sv
// dice_roller: pseudo-random dice roller for the game-logic datapath.
//   A free-running 16-bit Fibonacci LFSR supplies entropy. A qualified roll
//   request latches a face value in 1..N (N = 4/6/8/20 from die_select)
//   onto rolled_number, where it holds until the next roll or reset.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous active-low reset
//   die_select     in   2  00=d4, 01=d6, 10=d8, 11=d20
//   roll           in   1  roll request, sampled on rising clk
//   rolled_number  out  8  latched face value (0 only before the first roll)
//
// Build option:
//   DICE_ROLL_EDGE_EN  defined   -> one roll per rising edge of roll
//                      undefined -> re-roll every clock while roll is high
module dice_roller #(
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] die_select,
  input  logic       roll,
  output logic [7:0] rolled_number
);

  localparam int unsigned OUT_W = 8;

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt_c;
  logic              fb_c;
  logic [OUT_W-1:0]  face_c;
  logic              fire_c;
  // Set once roll has been sampled low after reset; a roll held high
  // through reset release must not fire.
  logic              armed;

  // Next LFSR state: x^16+x^14+x^13+x^11+1, reload SEED if ever all-zero.
  always_comb begin
    fb_c       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    lfsr_nxt_c = {lfsr[LFSR_W-2:0], fb_c};
    if (lfsr == '0) begin
      lfsr_nxt_c = SEED;
    end
  end

  // Face value from the pre-advance LFSR state; modulo bias is accepted.
  always_comb begin
    face_c = '0;
    case (die_select)
      2'b00:   face_c = OUT_W'(lfsr[1:0]) + OUT_W'(1);
      2'b01:   face_c = OUT_W'(lfsr % LFSR_W'(6)) + OUT_W'(1);
      2'b10:   face_c = OUT_W'(lfsr[2:0]) + OUT_W'(1);
      default: face_c = OUT_W'(lfsr % LFSR_W'(20)) + OUT_W'(1);
    endcase
  end

`ifdef DICE_ROLL_EDGE_EN
  logic roll_q;

  // Previous roll sample for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      roll_q <= 1'b0;
    end else begin
      roll_q <= roll;
    end
  end

  // One roll per rising edge of roll.
  always_comb begin
    fire_c = roll & ~roll_q & armed;
  end
`else
  // Re-roll every clock while roll is high.
  always_comb begin
    fire_c = roll & armed;
  end
`endif

  // LFSR, arm flag and latched output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr          <= SEED;
      armed         <= 1'b0;
      rolled_number <= '0;
    end else begin
      lfsr  <= lfsr_nxt_c;
      armed <= armed | ~roll;
      if (fire_c) begin
        rolled_number <= face_c;
      end
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: directed + randomized checks of dice_roller against a
// reference model built from a precomputed LFSR state sequence.
module tb_dice_roller;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          NSEQ  = 4096;
`ifdef DICE_ROLL_EDGE_EN
  localparam bit          EDGE  = 1'b1;
`else
  localparam bit          EDGE  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] die_select = 2'b00;
  logic       roll = 1'b0;
  logic [7:0] rolled_number;

  dice_roller dut (
    .clk          (clk),
    .reset        (reset),
    .die_select   (die_select),
    .roll         (roll),
    .rolled_number(rolled_number)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // seq[k] = LFSR contents k clocks after reset release.
  logic [15:0] seq [NSEQ];
  int          k;
  bit          m_prev_roll;
  bit          m_seen_low;
  logic [7:0]  m_out;
  bit          hit [21];

  function automatic int sides(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 6;
      2'b10:   return 8;
      default: return 20;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Assert reset away from a clock edge and confirm the output clears at once.
  task automatic do_reset();
    reset       = 1'b0;
    k           = 0;
    m_prev_roll = 1'b0;
    m_seen_low  = 1'b0;
    m_out       = 8'd0;
    #1;
    chk("async_reset", rolled_number, 8'd0);
  endtask

  // One clock: update the model with the inputs sampled at this edge, then check.
  task automatic cyc(input string tag);
    int  n;
    bit  fire;
    @(posedge clk);
    if (reset) begin
      n    = sides(die_select);
      fire = roll && m_seen_low && (!EDGE || !m_prev_roll);
      if (fire) m_out = 8'((int'(seq[k]) % n) + 1);
      if (!roll) m_seen_low = 1'b1;
      m_prev_roll = roll;
      k++;
    end
    #1;
    chk(tag, rolled_number, m_out);
  endtask

  logic [7:0] first_run;
  int         n_cur;

  initial begin
    // Reference LFSR sequence from the polynomial definition.
    seq[0] = SEED;
    for (int i = 1; i < NSEQ; i++) begin
      logic [15:0] l;
      l = seq[i-1];
      seq[i] = (l == 16'd0) ? SEED : {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end

    // 1. Reset for 2 clocks, then idle 10 clocks: output stays 0.
    reset = 1'b1;
    #1;
    do_reset();
    repeat (2) cyc("reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle_zero");

    // 2. d4, roll held high 5 clocks.
    die_select = 2'b00;
    roll = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("d4_hold");
      chk("d4_range", 8'((rolled_number >= 8'd1 && rolled_number <= 8'd4) ? 1 : 0), 8'd1);
    end
    roll = 1'b0;
    cyc("d4_release");

    // 3. 200 pulses per die, 3 idle clocks between; full face coverage.
    for (int d = 0; d < 4; d++) begin
      do_reset();
      reset = 1'b1;
      die_select = 2'(d);
      n_cur = sides(die_select);
      for (int f = 0; f < 21; f++) hit[f] = 1'b0;
      cyc("pre_idle");
      for (int p = 0; p < 200; p++) begin
        roll = 1'b1;
        cyc("pulse");
        if (rolled_number >= 8'd1 && rolled_number <= 8'd20) hit[rolled_number] = 1'b1;
        chk("range", 8'((rolled_number >= 8'd1 && int'(rolled_number) <= n_cur) ? 1 : 0), 8'd1);
        chk("hi_bits", 8'(rolled_number[7:5]), 8'd0);
        roll = 1'b0;
        repeat (3) cyc("gap");
      end
      for (int f = 1; f <= n_cur; f++) chk("face_hit", 8'(hit[f]), 8'd1);
    end

    // Randomized: random roll/die_select per clock, including die changes without a roll.
    for (int i = 0; i < 300; i++) begin
      roll       = 1'($urandom_range(0, 1));
      die_select = 2'($urandom);
      cyc("random");
    end
    roll = 1'b0;
    cyc("random_end");

    // 4. d20 roll held high, reset mid-roll, release with roll still high.
    die_select = 2'b11;
    cyc("d20_prep");
    roll = 1'b1;
    repeat (3) cyc("d20_hold");
    do_reset();
    cyc("in_reset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc("held_through_release");
    roll = 1'b0;
    cyc("rearm_low");
    roll = 1'b1;
    cyc("rearm_fire");
    chk("rearm_nonzero", 8'((rolled_number != 8'd0) ? 1 : 0), 8'd1);
    roll = 1'b0;
    cyc("rearm_end");

    // 5. Determinism: 5 clocks after release, one d6 pulse, twice.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      cyc("det_reset");
      reset = 1'b1;
      die_select = 2'b01;
      repeat (5) cyc("det_wait");
      roll = 1'b1;
      cyc("det_pulse");
      chk("det_ref", rolled_number, 8'((int'(seq[5]) % 6) + 1));
      if (run == 0) first_run = m_out;
      else chk("det_repeat", rolled_number, first_run);
      roll = 1'b0;
      cyc("det_end");
    end

    // 6. d8, roll held high 8 clocks.
    die_select = 2'b10;
    roll = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc("d8_hold");
      chk("d8_range", 8'((rolled_number >= 8'd1 && rolled_number <= 8'd8) ? 1 : 0), 8'd1);
    end
    roll = 1'b0;
    cyc("d8_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
